// File: rtl/spi_sck_receiver.sv
// SPI slave receiver clocked entirely from clock_in: oversamples an asynchronous SCK/CS/SDI,
// assembles WIDTH-bit MSB-first words and measures the SCK high time.
module spi_sck_receiver #(
   parameter int unsigned WIDTH   = 24,
   parameter logic [27:0] TIMEOUT = 28'd1024
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             sck_in,
   input  logic             cs_n,
   input  logic             sdi,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_error,
   output logic [27:0]      high_time
);

   localparam int unsigned   CntW        = $clog2(WIDTH + 2);
   localparam logic [CntW-1:0] FullCnt   = CntW'(WIDTH);
   localparam logic [27:0]   TimeoutLast = TIMEOUT - 28'd1;
   localparam logic [27:0]   HighMax     = 28'hFFFFFFF;

   typedef enum logic [1:0] {StIdle, StShift, StDone, StError} state_e;

   state_e           state_q, state_d;
   logic [2:0]       sck_sync_q, cs_sync_q;
   logic [1:0]       sdi_sync_q;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [27:0]      tmo_q, tmo_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             frame_error_q, frame_error_d;
   logic [27:0]      high_cnt_q, high_cnt_d;
   logic [27:0]      high_time_q, high_time_d;

   logic sck_s, sdi_s, sck_rise, sck_fall, cs_rise, cs_fall;

   // Stage 2 is the synchronised level, stage 3 its one-cycle-old copy for edge detection.
   assign sck_s    = sck_sync_q[1];
   assign sdi_s    = sdi_sync_q[1];
   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
   assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
   assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];

   always_ff @(posedge clock_in) begin
      if (reset) begin
         sck_sync_q    <= 3'b000;
         cs_sync_q     <= 3'b111;
         sdi_sync_q    <= 2'b00;
         state_q       <= StIdle;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         tmo_q         <= '0;
         data_out_q    <= '0;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         high_cnt_q    <= '0;
         high_time_q   <= '0;
      end else begin
         sck_sync_q    <= {sck_sync_q[1:0], sck_in};
         cs_sync_q     <= {cs_sync_q[1:0], cs_n};
         sdi_sync_q    <= {sdi_sync_q[0], sdi};
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         tmo_q         <= tmo_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         frame_error_q <= frame_error_d;
         high_cnt_q    <= high_cnt_d;
         high_time_q   <= high_time_d;
      end
   end

   // Frame FSM; data_valid/frame_error are registered on entry to DONE/ERROR so they are
   // visible while the FSM sits in that state.
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      tmo_d         = tmo_q;
      data_out_d    = data_out_q;
      data_valid_d  = 1'b0;
      frame_error_d = frame_error_q;

      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  state_d       = StShift;
                  shift_d       = '0;
                  bit_cnt_d     = '0;
                  tmo_d         = '0;
                  frame_error_d = 1'b0;
               end
            end
            StShift: begin
               if (cs_rise) begin
                  if (bit_cnt_q == FullCnt) begin
                     state_d      = StDone;
                     data_out_d   = shift_q;
                     data_valid_d = 1'b1;
                  end else begin
                     state_d       = StError;
                     frame_error_d = 1'b1;
                  end
               end else if (sck_rise) begin
                  if (bit_cnt_q == FullCnt) begin
                     state_d       = StError;
                     frame_error_d = 1'b1;
                  end else begin
                     shift_d   = {shift_q[WIDTH-2:0], sdi_s};
                     bit_cnt_d = bit_cnt_q + CntW'(1);
                     tmo_d     = '0;
                  end
               end else if (tmo_q == TimeoutLast) begin
                  state_d       = StError;
                  frame_error_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 28'd1;
               end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      high_cnt_d  = high_cnt_q;
      high_time_d = high_time_q;
      if (!enable) begin
         high_cnt_d = '0;
      end else if (sck_fall) begin
         high_time_d = high_cnt_q;
         high_cnt_d  = '0;
      end else if (sck_s && (high_cnt_q != HighMax)) begin
         high_cnt_d = high_cnt_q + 28'd1;
      end
   end

   assign data_out    = data_out_q;
   assign data_valid  = data_valid_q;
   assign frame_error = frame_error_q;
   assign high_time   = high_time_q;

endmodule

// File: tb/tb_spi_sck_receiver.sv
// Randomised bench for spi_sck_receiver: frame driver pushes expected outcomes into a
// scoreboard queue, an independent monitor pops them when the DUT reports valid/error.
module tb_spi_sck_receiver;

   localparam int unsigned W   = 24;
   localparam int unsigned TMO = 1024;

   localparam int EndCs     = 0;
   localparam int EndTmo    = 1;
   localparam int EndEnable = 2;
   localparam int EndReset  = 3;
   localparam int EndSame   = 4;

   typedef struct packed {
      logic          is_err;
      logic [W-1:0]  data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          sck = 1'b0;
   logic          cs_n = 1'b1;
   logic          sdi = 1'b0;
   logic [W-1:0]  data_out;
   logic          data_valid;
   logic          frame_error;
   logic [27:0]   high_time;

   exp_t          sb[$];
   logic [W-1:0]  last_good = '0;
   logic          prev_fe = 1'b0;
   int            checks = 0;
   int            errors = 0;

   spi_sck_receiver #(
      .WIDTH   (W),
      .TIMEOUT (28'(TMO))
   ) dut (
      .clock_in    (clk),
      .reset       (reset),
      .enable      (enable),
      .sck_in      (sck),
      .cs_n        (cs_n),
      .sdi         (sdi),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_error (frame_error),
      .high_time   (high_time)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference outcome of one frame from its bit count and how it ends.
   task automatic predict(input logic [W-1:0] val, input int nbits, input int ending);
      exp_t e;
      if (ending == EndEnable || ending == EndReset) return;
      e.data = val;
      if (ending == EndTmo) e.is_err = 1'b1;
      else if (nbits > int'(W)) e.is_err = 1'b1;
      else e.is_err = (nbits != int'(W));
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [W-1:0] val, input int nbits, input int hi,
                             input int lo, input int ending);
      predict(val, nbits, ending);
      cs_n = 1'b0;
      tick(3);
      for (int i = 0; i < nbits; i++) begin
         if (i < int'(W)) sdi = val[W-1-i];
         else sdi = 1'($urandom_range(0, 1));
         sck = 1'b0;
         tick(lo);
         sck = 1'b1;
         tick(hi);
      end
      sck = 1'b0;
      tick(lo);
      case (ending)
         EndTmo: begin
            tick(TMO + 10);
            cs_n = 1'b1;
         end
         EndEnable: begin
            enable = 1'b0;
            tick(3);
            cs_n = 1'b1;
            tick(6);
            enable = 1'b1;
         end
         EndReset: begin
            reset = 1'b1;
            cs_n  = 1'b1;
            tick(3);
            reset = 1'b0;
            last_good = '0;
         end
         EndSame: begin
            sck  = 1'b1;
            cs_n = 1'b1;
            tick(hi);
            sck = 1'b0;
         end
         default: cs_n = 1'b1;
      endcase
      tick(10);
      check("pending_expectations", 32'(sb.size()), 32'd0);
      if (ending == EndReset) begin
         check("rst_data_out", 32'(data_out), 32'd0);
         check("rst_frame_error", 32'(frame_error), 32'd0);
         check("rst_high_time", 32'(high_time), 32'd0);
      end else if (nbits > 0) begin
         check("high_time", 32'(high_time), 32'(hi));
      end
   endtask

   // Monitor: every valid pulse and every frame_error rise must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_fe = frame_error;
      end else begin
         if (data_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: data_out 0x%0h with no frame expected", data_out);
            end else begin
               e = sb.pop_front();
               check("valid_expected_kind", 32'(e.is_err), 32'd0);
               check("data_out", 32'(data_out), 32'(e.data));
               check("fe_at_valid", 32'(frame_error), 32'd0);
               last_good = e.data;
            end
         end
         if (frame_error && !prev_fe) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_error: frame_error rose with no error expected");
            end else begin
               e = sb.pop_front();
               check("error_expected_kind", 32'(e.is_err), 32'd1);
               check("data_out_held", 32'(data_out), 32'(last_good));
            end
         end
         prev_fe = frame_error;
      end
   end

   initial begin
      #1800000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, hi, lo, ending, r;
      tick(4);
      check("reset_data_out", 32'(data_out), 32'd0);
      check("reset_data_valid", 32'(data_valid), 32'd0);
      check("reset_frame_error", 32'(frame_error), 32'd0);
      check("reset_high_time", 32'(high_time), 32'd0);
      reset  = 1'b0;
      enable = 1'b1;
      tick(5);

      send_frame(24'hA5C3F0, 24, 4, 4, EndCs);
      check("good_frame_fe", 32'(frame_error), 32'd0);
      send_frame(24'hA5C3F0, 23, 4, 4, EndCs);
      check("short_frame_fe", 32'(frame_error), 32'd1);
      check("short_frame_data", 32'(data_out), 32'hA5C3F0);
      send_frame(24'h123456, 25, 4, 4, EndCs);
      check("overrun_fe", 32'(frame_error), 32'd1);
      send_frame(24'h0F0F0F, 10, 4, 4, EndTmo);
      check("timeout_fe", 32'(frame_error), 32'd1);
      send_frame(24'h5A5A5A, 24, 3, 5, EndCs);
      check("after_timeout_fe", 32'(frame_error), 32'd0);
      check("after_timeout_data", 32'(data_out), 32'h5A5A5A);

      send_frame(24'hFFFFFF, 12, 4, 4, EndReset);
      send_frame(24'h000001, 24, 4, 4, EndCs);
      check("post_reset_data", 32'(data_out), 32'h000001);
      check("post_reset_fe", 32'(frame_error), 32'd0);

      send_frame(24'hC0FFEE, 9, 4, 4, EndEnable);
      check("enable_drop_fe", 32'(frame_error), 32'd0);
      check("enable_drop_data", 32'(data_out), 32'h000001);
      sck = 1'b1;
      tick(40);
      sck = 1'b0;
      tick(8);
      check("high_time_40", 32'(high_time), 32'd40);

      send_frame(24'h3C3C3C, 24, 5, 3, EndSame);
      check("same_cycle_data", 32'(data_out), 32'h3C3C3C);

      for (int k = 0; k < 30; k++) begin
         r = int'($urandom_range(0, 7));
         if (r <= 3) nb = int'(W);
         else if (r == 4) nb = int'(W) - 1;
         else if (r == 5) nb = int'(W) + 1;
         else nb = int'($urandom_range(1, W - 2));
         hi = int'($urandom_range(3, 6));
         lo = int'($urandom_range(3, 6));
         ending = ($urandom_range(0, 3) == 0) ? EndSame : EndCs;
         send_frame(W'($urandom), nb, hi, lo, ending);
         tick(int'($urandom_range(0, 4)));
      end

      check("final_queue_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
